// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the I-cache refill path
// and the D-cache refill/write-back path; one transaction at a time, all outputs registered.
module mem_port_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RELEASE
  } state_t;

  state_t state;
  logic   last_grant_d;
  logic   i_req;
  logic   d_req;
  logic   grant_d;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // D wins when it is alone, or on a tie when I was served last.
  always_comb begin
    grant_d = d_req && (!i_req || !last_grant_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last_grant_d <= 1'b0;
      i_rdata      <= '0;
      i_ready      <= 1'b0;
      d_rdata      <= '0;
      d_ready      <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            mem_addr     <= d_addr;
            mem_wdata    <= d_wdata;
            mem_write    <= d_write;
            mem_read     <= ~d_write;
            last_grant_d <= 1'b1;
            state        <= BUSY_D;
          end else if (i_req) begin
            mem_addr     <= i_addr;
            mem_write    <= 1'b0;
            mem_read     <= 1'b1;
            last_grant_d <= 1'b0;
            state        <= BUSY_I;
          end
        end
        BUSY_I: begin
          if (mem_ready) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            i_ready   <= 1'b1;
            i_rdata   <= mem_rdata;
            state     <= RELEASE;
          end
        end
        BUSY_D: begin
          if (mem_ready) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            d_ready   <= 1'b1;
            // A write-back returns nothing, so the last read line is kept.
            if (!mem_write) begin
              d_rdata <= mem_rdata;
            end
            state <= RELEASE;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: hand-computed expectations checked by immediate assertions.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic         clk;
  logic         rst;
  logic         i_read;
  logic [27:0]  i_addr;
  logic [127:0] i_rdata;
  logic         i_ready;
  logic         d_read;
  logic         d_write;
  logic [27:0]  d_addr;
  logic [127:0] d_wdata;
  logic [127:0] d_rdata;
  logic         d_ready;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  int vectors = 0;
  int miscompares = 0;
  logic [127:0] exp_i_rdata;
  logic [127:0] exp_d_rdata;

  mem_port_arbiter #(.ADDR_W(28), .DATA_W(128)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit ir, input logic [27:0] ia, input bit dr, input bit dw,
                               input logic [27:0] da, input logic [127:0] dwd);
    i_read  = ir;
    i_addr  = ia;
    d_read  = dr;
    d_write = dw;
    d_addr  = da;
    d_wdata = dwd;
  endtask

  // Waits for the grant, checks the latched request, answers after lat cycles and checks completion.
  task automatic serveOne(input bit exp_d, input bit is_write, input logic [27:0] exp_addr,
                          input logic [127:0] exp_wdata, input logic [127:0] rdata,
                          input int lat, input bit drop_req);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cyc();
      if (mem_read || mem_write) seen = 1'b1;
    end
    checkOutput("grant_seen", {127'd0, seen}, 128'd1);
    if (!seen) return;
    checkOutput("mem_addr", {100'd0, mem_addr}, {100'd0, exp_addr});
    checkOutput("mem_read_dir", {127'd0, mem_read}, {127'd0, !is_write});
    checkOutput("mem_write_dir", {127'd0, mem_write}, {127'd0, is_write});
    checkOutput("busy_i_ready", {127'd0, i_ready}, 128'd0);
    checkOutput("busy_d_ready", {127'd0, d_ready}, 128'd0);
    if (is_write) checkOutput("mem_wdata", mem_wdata, exp_wdata);
    for (int k = 0; k < lat; k++) begin
      cyc();
      checkOutput("hold_addr", {100'd0, mem_addr}, {100'd0, exp_addr});
      checkOutput("hold_strobe", {127'd0, (mem_read | mem_write)}, 128'd1);
    end
    mem_rdata = rdata;
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    mem_rdata = '0;
    if (!exp_d) exp_i_rdata = rdata;
    else if (!is_write) exp_d_rdata = rdata;
    checkOutput("i_ready_pulse", {127'd0, i_ready}, {127'd0, !exp_d});
    checkOutput("d_ready_pulse", {127'd0, d_ready}, {127'd0, exp_d});
    checkOutput("release_mem_read", {127'd0, mem_read}, 128'd0);
    checkOutput("release_mem_write", {127'd0, mem_write}, 128'd0);
    checkOutput("i_rdata", i_rdata, exp_i_rdata);
    checkOutput("d_rdata", d_rdata, exp_d_rdata);
    if (drop_req) begin
      if (exp_d) begin
        d_read  = 1'b0;
        d_write = 1'b0;
      end else begin
        i_read = 1'b0;
      end
    end
    cyc();
    checkOutput("pulse_end_i", {127'd0, i_ready}, 128'd0);
    checkOutput("pulse_end_d", {127'd0, d_ready}, 128'd0);
    checkOutput("idle_mem_read", {127'd0, mem_read}, 128'd0);
  endtask

  initial begin
    rst       = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = '0;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    applyStimulus(0, 28'h0, 0, 0, 28'h0, 128'h0);
    cyc();
    cyc();
    checkOutput("rst_mem_read", {127'd0, mem_read}, 128'd0);
    checkOutput("rst_mem_write", {127'd0, mem_write}, 128'd0);
    checkOutput("rst_mem_addr", {100'd0, mem_addr}, 128'd0);
    checkOutput("rst_i_ready", {127'd0, i_ready}, 128'd0);
    checkOutput("rst_d_ready", {127'd0, d_ready}, 128'd0);
    checkOutput("rst_i_rdata", i_rdata, 128'd0);
    rst = 1'b0;
    cyc();

    $display("[TB] single I-cache refill");
    applyStimulus(1, 28'h0000040, 0, 0, 28'h0, 128'h0);
    serveOne(0, 0, 28'h0000040, 128'h0, {16{8'hA5}}, 2, 1);

    $display("[TB] simultaneous requests after reset");
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    applyStimulus(1, 28'h00000A1, 1, 0, 28'h00000D1, 128'h0);
    serveOne(1, 0, 28'h00000D1, 128'h0, {16{8'h11}}, 1, 1);
    serveOne(0, 0, 28'h00000A1, 128'h0, {16{8'h22}}, 1, 1);
    cyc();
    checkOutput("quiet_i_ready", {127'd0, i_ready}, 128'd0);
    checkOutput("quiet_d_ready", {127'd0, d_ready}, 128'd0);
    checkOutput("quiet_mem_read", {127'd0, mem_read}, 128'd0);

    $display("[TB] continuous contention");
    applyStimulus(1, 28'h0000100, 1, 0, 28'h0000200, 128'h0);
    for (int t = 0; t < 6; t++) begin
      if (t % 2 == 0) serveOne(1, 0, 28'h0000200, 128'h0, {16{8'h30}} + 128'(t), 0, 0);
      else            serveOne(0, 0, 28'h0000100, 128'h0, {16{8'h40}} + 128'(t), 0, 0);
    end
    applyStimulus(0, 28'h0, 0, 0, 28'h0, 128'h0);
    cyc();

    $display("[TB] write-back wins over read");
    applyStimulus(0, 28'h0, 1, 1, 28'h0000333, 128'h1234);
    serveOne(1, 1, 28'h0000333, 128'h1234, {16{8'hFF}}, 1, 1);

    $display("[TB] address change while busy, stray mem_ready");
    applyStimulus(0, 28'h0, 1, 0, 28'h0000055, 128'h0);
    cyc();
    checkOutput("t5_mem_read", {127'd0, mem_read}, 128'd1);
    checkOutput("t5_mem_addr", {100'd0, mem_addr}, 128'h55);
    d_addr  = 28'h0000077;
    d_wdata = 128'hDEAD;
    for (int k = 0; k < 10; k++) begin
      cyc();
      checkOutput("t5_hold_addr", {100'd0, mem_addr}, 128'h55);
    end
    mem_rdata = {16{8'hC3}};
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    d_read = 1'b0;
    exp_d_rdata = {16{8'hC3}};
    checkOutput("t5_d_ready", {127'd0, d_ready}, 128'd1);
    checkOutput("t5_d_rdata", d_rdata, exp_d_rdata);
    cyc();
    mem_rdata = {16{8'h5A}};
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    checkOutput("t5_stray_d_ready", {127'd0, d_ready}, 128'd0);
    checkOutput("t5_stray_i_ready", {127'd0, i_ready}, 128'd0);
    checkOutput("t5_stray_d_rdata", d_rdata, exp_d_rdata);
    checkOutput("t5_stray_mem_read", {127'd0, mem_read}, 128'd0);
    cyc();
    checkOutput("t5_after_d_ready", {127'd0, d_ready}, 128'd0);

    $display("[TB] reset during I transaction");
    applyStimulus(1, 28'h0000066, 0, 0, 28'h0, 128'h0);
    cyc();
    checkOutput("t6_busy", {127'd0, mem_read}, 128'd1);
    #2 rst = 1'b1;
    #1;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    checkOutput("t6_mem_read", {127'd0, mem_read}, 128'd0);
    checkOutput("t6_i_ready", {127'd0, i_ready}, 128'd0);
    checkOutput("t6_d_ready", {127'd0, d_ready}, 128'd0);
    checkOutput("t6_mem_addr", {100'd0, mem_addr}, 128'd0);
    checkOutput("t6_d_rdata", d_rdata, 128'd0);
    cyc();
    rst = 1'b0;
    serveOne(0, 0, 28'h0000066, 128'h0, {16{8'h9E}}, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
